// File: rtl/intr_arb_pkg.sv
// Purpose: shared constants and types for the interrupt priority arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default priority width, register byte offsets within the page, scan FSM state type.
package intr_arb_pkg;

  localparam int PRIO_W_DEF = 3;

  // Byte offsets within the 4 KiB page; decode compares offset bits [11:2].
  localparam logic [11:0] OFF_PRIO    = 12'h000;
  localparam logic [11:0] OFF_THRESH  = 12'h800;
  localparam logic [11:0] OFF_CLAIM   = 12'h804;
  localparam logic [11:0] OFF_PENDING = 12'h808;

  typedef enum logic [0:0] {S_SCAN, S_COMMIT} arb_state_t;

endpackage

// File: rtl/intr_gateway.sv
// Purpose: per-source request gateway holding pending / in_flight state.
// Latency: pending rises one cycle after the qualifying request is sampled.
// Backpressure: none; a request seen while pending or in flight is merged
//   (level mode) or parked in a 1-deep edge_seen bit (edge mode).
// Ports: clk, rst (sync, active-high); irq raw request; claim clears pending and
//   marks in flight; complete ends the in-flight period; pending to the scanner.
// Config: INTR_ARB_EDGE_EN selects rising-edge capture instead of level capture.
module intr_gateway (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending
);

  logic pending_q, pending_d;
  logic in_flight_q, in_flight_d;

`ifdef INTR_ARB_EDGE_EN
  logic irq_d_q, irq_d_d;
  logic edge_seen_q, edge_seen_d;
  logic rise;

  always_comb begin
    rise        = irq & ~irq_d_q;
    irq_d_d     = irq;
    pending_d   = pending_q;
    edge_seen_d = edge_seen_q;
    in_flight_d = in_flight_q;
    if (complete) in_flight_d = 1'b0;
    if (claim)    in_flight_d = 1'b1;

    if (claim) begin
      // An edge arriving on the claim cycle belongs to the next service round.
      pending_d = 1'b0;
      if (rise) edge_seen_d = 1'b1;
    end else if (~pending_q & ~in_flight_q & (rise | edge_seen_q)) begin
      pending_d   = 1'b1;
      edge_seen_d = 1'b0;
    end else if (rise & in_flight_q) begin
      edge_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 1'b0;
      in_flight_q <= 1'b0;
      irq_d_q     <= 1'b0;
      edge_seen_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      in_flight_q <= in_flight_d;
      irq_d_q     <= irq_d_d;
      edge_seen_q <= edge_seen_d;
    end
  end
`else
  always_comb begin
    pending_d   = pending_q;
    in_flight_d = in_flight_q;
    if (complete) in_flight_d = 1'b0;
    if (claim)    in_flight_d = 1'b1;

    // in_flight_q (not _d) gates the set, so a complete and a new request on
    // the same cycle re-pend one cycle later.
    if (claim)
      pending_d = 1'b0;
    else if (irq & ~pending_q & ~in_flight_q)
      pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q   <= 1'b0;
      in_flight_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      in_flight_q <= in_flight_d;
    end
  end
`endif

  assign pending = pending_q;

endmodule

// File: rtl/intr_priority_arbiter.sv
// Purpose: memory-mapped interrupt scheduler ranking pending sources by priority.
// Latency: bus gnt 1 cycle after req, rvalid 1 cycle after gnt; request to
//   intr_signal at most 2*(N_SRC-1)+2 cycles (one sweep of N_SRC-1 plus commit, twice).
// Backpressure: one bus access per two cycles (no accept while gnt is high).
// Ports: clk, rst (sync, active-high); data_* slave bus; irq_source raw
//   requests (bit 0 ignored); intr_id / intr_signal committed winner.
// Config: INTR_ARB_EDGE_EN (in intr_gateway) switches gateways to edge capture.
module intr_priority_arbiter
  import intr_arb_pkg::*;
#(
  parameter int          N_SRC     = 32,
  parameter int          PRIO_W    = PRIO_W_DEF,
  parameter logic [19:0] BASE_PAGE = 20'h00023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_req,
  input  logic             data_we,
  input  logic [3:0]       data_be,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_gnt,
  output logic             data_rvalid,
  output logic [31:0]      data_rdata,
  input  logic [N_SRC-1:0] irq_source,
  output logic [15:0]      intr_id,
  output logic             intr_signal
);

  localparam int          ID_W    = $clog2(N_SRC);
  localparam int          PEND_W  = (N_SRC < 32) ? N_SRC : 32;
  localparam logic [9:0]  N_SRC_L = 10'(N_SRC);
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_SRC - 1);

  // Bus-side state
  logic              data_gnt_q, data_gnt_d;
  logic              data_rvalid_q, data_rvalid_d;
  logic [31:0]       data_rdata_q, data_rdata_d;
  logic [PRIO_W-1:0] prio_q [N_SRC];
  logic [PRIO_W-1:0] prio_d [N_SRC];
  logic [PRIO_W-1:0] thresh_q, thresh_d;

  // Scanner state
  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   idx_q, idx_d;
  logic [ID_W-1:0]   best_id_q, best_id_d;
  logic [PRIO_W-1:0] best_prio_q, best_prio_d;
  logic [ID_W-1:0]   intr_id_q, intr_id_d;
  logic              intr_signal_q, intr_signal_d;

  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  claim_vec;
  logic [N_SRC-1:0]  comp_vec;

  logic              decode, accept;
  logic [9:0]        word_off;
  logic [8:0]        prio_idx;
  logic              hit_prio, hit_thresh, hit_claim, hit_pending;
  logic              claim_fire, complete_fire;
  logic [31:0]       rd_val;

  // Address decode and per-source claim/complete strobes
  always_comb begin
    decode        = (data_addr[31:12] == BASE_PAGE);
    accept        = data_req & decode & ~data_gnt_q;
    word_off      = data_addr[11:2];
    prio_idx      = data_addr[10:2];
    hit_prio      = ~data_addr[11] & (prio_idx != 9'd0) & ({1'b0, prio_idx} < N_SRC_L);
    hit_thresh    = (word_off == OFF_THRESH[11:2]);
    hit_claim     = (word_off == OFF_CLAIM[11:2]);
    hit_pending   = (word_off == OFF_PENDING[11:2]);
    claim_fire    = accept & ~data_we & hit_claim & (intr_id_q != '0);
    complete_fire = accept & data_we & hit_claim;

    claim_vec = '0;
    comp_vec  = '0;
    for (int i = 1; i < N_SRC; i++) begin
      claim_vec[i] = claim_fire & (intr_id_q == ID_W'(i));
      comp_vec[i]  = complete_fire & (data_wdata[15:0] == 16'(i));
    end
  end

  // Register file, read mux and bus handshake
  always_comb begin
    prio_d        = prio_q;
    thresh_d      = thresh_q;
    data_gnt_d    = accept;
    data_rvalid_d = data_gnt_q;
    data_rdata_d  = data_rdata_q;

    rd_val = '0;
    if (hit_prio) begin
      for (int i = 1; i < N_SRC; i++)
        if (prio_idx == 9'(i)) rd_val[PRIO_W-1:0] = prio_q[i];
    end else if (hit_thresh) begin
      rd_val[PRIO_W-1:0] = thresh_q;
    end else if (hit_claim) begin
      rd_val[ID_W-1:0] = intr_id_q;
    end else if (hit_pending) begin
      for (int i = 0; i < PEND_W; i++) rd_val[i] = pending[i];
    end

    if (accept) begin
      data_rdata_d = data_we ? 32'd0 : rd_val;
      if (data_we & data_be[0]) begin
        if (hit_thresh) thresh_d = data_wdata[PRIO_W-1:0];
        if (hit_prio) begin
          for (int i = 1; i < N_SRC; i++)
            if (prio_idx == 9'(i)) prio_d[i] = data_wdata[PRIO_W-1:0];
        end
      end
    end
  end

  // Scanner: one source per cycle, then a single commit cycle
  logic              cand_qual;
  logic              best_claimed;
  logic [ID_W-1:0]   best_id_v;
  logic [PRIO_W-1:0] best_prio_v;

  always_comb begin
    // A source being claimed this cycle still shows pending_q=1; exclude it.
    cand_qual    = pending[idx_q] & (prio_q[idx_q] > thresh_q) & ~claim_vec[idx_q];
    best_claimed = claim_fire & (best_id_q == intr_id_q);
    best_id_v    = best_claimed ? '0 : best_id_q;
    best_prio_v  = best_claimed ? '0 : best_prio_q;

    state_d       = state_q;
    idx_d         = idx_q;
    best_id_d     = best_id_v;
    best_prio_d   = best_prio_v;
    intr_id_d     = intr_id_q;
    intr_signal_d = intr_signal_q;

    if (claim_fire) begin
      intr_id_d     = '0;
      intr_signal_d = 1'b0;
    end

    case (state_q)
      S_SCAN: begin
        // Strict compare with an ascending walk leaves ties with the lower id.
        if (cand_qual && (prio_q[idx_q] > best_prio_v)) begin
          best_id_d   = idx_q;
          best_prio_d = prio_q[idx_q];
        end
        if (idx_q == LAST_IDX) state_d = S_COMMIT;
        else                   idx_d   = idx_q + ID_W'(1);
      end
      S_COMMIT: begin
        intr_id_d     = best_id_v;
        intr_signal_d = (best_id_v != '0);
        best_id_d     = '0;
        best_prio_d   = '0;
        idx_d         = ID_W'(1);
        state_d       = S_SCAN;
      end
      default: begin
        state_d = S_SCAN;
        idx_d   = ID_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_gnt_q    <= 1'b0;
      data_rvalid_q <= 1'b0;
      data_rdata_q  <= '0;
      prio_q        <= '{default: '0};
      thresh_q      <= '0;
      state_q       <= S_SCAN;
      idx_q         <= ID_W'(1);
      best_id_q     <= '0;
      best_prio_q   <= '0;
      intr_id_q     <= '0;
      intr_signal_q <= 1'b0;
    end else begin
      data_gnt_q    <= data_gnt_d;
      data_rvalid_q <= data_rvalid_d;
      data_rdata_q  <= data_rdata_d;
      prio_q        <= prio_d;
      thresh_q      <= thresh_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      best_id_q     <= best_id_d;
      best_prio_q   <= best_prio_d;
      intr_id_q     <= intr_id_d;
      intr_signal_q <= intr_signal_d;
    end
  end

  // Source 0 is reserved: no gateway, never pending.
  assign pending[0] = 1'b0;

  for (genvar g = 1; g < N_SRC; g++) begin : g_gw
    intr_gateway u_gw (
      .clk      (clk),
      .rst      (rst),
      .irq      (irq_source[g]),
      .claim    (claim_vec[g]),
      .complete (comp_vec[g]),
      .pending  (pending[g])
    );
  end

  assign data_gnt    = data_gnt_q;
  assign data_rvalid = data_rvalid_q;
  assign data_rdata  = data_rdata_q;
  assign intr_id     = {{(16 - ID_W){1'b0}}, intr_id_q};
  assign intr_signal = intr_signal_q;

  logic unused_bits;
  assign unused_bits = ^{data_be[3:1], data_wdata[31:16], irq_source[0], comp_vec[0]};

endmodule

// File: tb/tb_intr_priority_arbiter.sv
module tb_intr_priority_arbiter;

  localparam int          N_SRC = 32;
  localparam logic [19:0] PAGE  = 20'h00023;
  localparam int          BOUND = 2 * (N_SRC - 1) + 2 + 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             data_req;
  logic             data_we;
  logic [3:0]       data_be;
  logic [31:0]      data_addr;
  logic [31:0]      data_wdata;
  logic             data_gnt;
  logic             data_rvalid;
  logic [31:0]      data_rdata;
  logic [N_SRC-1:0] irq_source;
  logic [15:0]      intr_id;
  logic             intr_signal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       nm;
  } sb_ent_t;

  sb_ent_t sb_q[$];
  sb_ent_t mon_e;

  intr_priority_arbiter #(.N_SRC(N_SRC), .PRIO_W(3), .BASE_PAGE(PAGE)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .irq_source  (irq_source),
    .intr_id     (intr_id),
    .intr_signal (intr_signal)
  );

  always #5 clk = ~clk;

  // Monitor: every response pops one scoreboard entry.
  always @(negedge clk) begin
    if (data_rvalid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: response with empty scoreboard, rdata=%h", data_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) begin
          checks++;
          if (data_rdata !== mon_e.exp) begin
            errors++;
            $display("FAIL %s: rdata got %h expected %h", mon_e.nm, data_rdata, mon_e.exp);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus access; returns just after the grant edge.
  task automatic bus(input logic we, input logic [11:0] off, input logic [3:0] be,
                     input logic [31:0] wd, input logic c, input logic [31:0] exp,
                     input string nm);
    sb_ent_t e;
    int n;
    e.chk = c; e.exp = exp; e.nm = nm;
    sb_q.push_back(e);
    @(negedge clk);
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = {PAGE, off};
    data_wdata = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!data_gnt && n < 8);
    data_req = 1'b0;
    data_we  = 1'b0;
    if (!data_gnt) begin
      checks++;
      errors++;
      $display("FAIL %s_gnt: no grant within 8 cycles, gnt=%b expected 1", nm, data_gnt);
      void'(sb_q.pop_back());
    end
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] wd);
    bus(1'b1, off, 4'hF, wd, 1'b0, 32'd0, "wr");
  endtask

  task automatic rd(input logic [11:0] off, input logic [31:0] exp, input string nm);
    bus(1'b0, off, 4'hF, 32'd0, 1'b1, exp, nm);
  endtask

  task automatic wait_id(input logic [15:0] exp, input string nm);
    int n;
    n = 0;
    while (intr_id !== exp && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {16'd0, intr_id}, {16'd0, exp});
    chk({nm, "_sig"}, {31'd0, intr_signal}, {31'd0, (exp != 16'd0)});
  endtask

  task automatic no_sig(input int cycles, input string nm);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (intr_signal) seen = 1'b1;
    end
    chk(nm, {31'd0, seen}, 32'd0);
  endtask

  task automatic pulse(input int src);
    @(negedge clk); irq_source[src] = 1'b1;
    @(negedge clk); irq_source[src] = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_be    = 4'h0;
    data_addr  = '0;
    data_wdata = '0;
    irq_source = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_intr_id", {16'd0, intr_id}, 32'd0);
    chk("rst_intr_signal", {31'd0, intr_signal}, 32'd0);
    rd(12'h004, 32'd0, "rst_prio1");
    rd(12'h800, 32'd0, "rst_thresh");
    rd(12'h804, 32'd0, "rst_claim");

    // Single source
    wr(12'h014, 32'd3);
    wr(12'h800, 32'd0);
    irq_source[5] = 1'b1;
    wait_id(16'd5, "id5");
    rd(12'h804, 32'd5, "claim5");
    chk("claim5_drop", {31'd0, intr_signal}, 32'd0);
    rd(12'h808, 32'd0, "pending_after_claim5");

`ifdef INTR_ARB_EDGE_EN
    // Held level does not re-trigger an edge gateway after complete.
    wr(12'h804, 32'd5);
    no_sig(BOUND, "edge_held_no_repend");
    irq_source[5] = 1'b0;
`else
    no_sig(BOUND, "level_inflight_no_resignal");
    wr(12'h804, 32'd5);
    wait_id(16'd5, "level_repend5");
    rd(12'h804, 32'd5, "claim5_again");
    irq_source[5] = 1'b0;
    wr(12'h804, 32'd5);
    wr(12'h804, 32'd9);
    rd(12'h808, 32'd0, "pending_after_complete9");
    no_sig(BOUND, "complete9_no_effect");
`endif

    // Equal priorities: lower id wins
    wr(12'h00C, 32'd2);
    wr(12'h01C, 32'd2);
    irq_source[3] = 1'b1;
    irq_source[7] = 1'b1;
    wait_id(16'd3, "tie_id3");
    rd(12'h804, 32'd3, "claim3");
    irq_source[3] = 1'b0;
    wr(12'h804, 32'd3);
    wait_id(16'd7, "tie_id7");
    rd(12'h804, 32'd7, "claim7");
    irq_source[7] = 1'b0;
    wr(12'h804, 32'd7);

    // Threshold: prio must strictly exceed it
    wr(12'h010, 32'd2);
    wr(12'h800, 32'd2);
    irq_source[4] = 1'b1;
    no_sig(BOUND, "thresh_eq_blocks");
    wr(12'h800, 32'd1);
    wait_id(16'd4, "thresh_lowered_id4");
    rd(12'h804, 32'd4, "claim4");
    irq_source[4] = 1'b0;
    wr(12'h804, 32'd4);

`ifdef INTR_ARB_EDGE_EN
    // Two edges while in flight collapse into one re-presentation.
    wr(12'h018, 32'd3);
    pulse(6);
    wait_id(16'd6, "edge_id6");
    rd(12'h804, 32'd6, "claim6");
    pulse(6);
    repeat (3) @(negedge clk);
    pulse(6);
    no_sig(BOUND, "edge_inflight_held");
    wr(12'h804, 32'd6);
    wait_id(16'd6, "edge_represent6");
    rd(12'h804, 32'd6, "claim6_again");
    wr(12'h804, 32'd6);
    no_sig(BOUND, "edge_only_once");
`endif

    // Register map boundaries
    wr(12'h000, 32'd7);
    rd(12'h000, 32'd0, "prio0_reserved");
    wr(12'h07C, 32'd5);
    rd(12'h07C, 32'd5, "prio31");
    wr(12'h080, 32'd7);
    rd(12'h080, 32'd0, "prio32_unmapped");
    bus(1'b1, 12'h014, 4'hE, 32'd6, 1'b0, 32'd0, "wr_be0_off");
    rd(12'h014, 32'd3, "prio5_be0_dropped");
    rd(12'h800, 32'd1, "thresh_readback");
    rd(12'h80C, 32'd0, "unmapped_80c");

    // Reset in the middle of operation
    irq_source[5] = 1'b1;
    wait_id(16'd5, "pre_reset_id5");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_id", {16'd0, intr_id}, 32'd0);
    chk("reset_mid_sig", {31'd0, intr_signal}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(12'h014, 32'd0, "post_reset_prio5");
    rd(12'h808, 32'h0000_0020, "post_reset_pending5");
    irq_source = '0;

    begin
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (sb_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb_q.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
